sync_unit: RTL and testbench

SYNC_UNIT -- requirements
Module: sync_unit

---
 rtl/sync_unit_pkg.sv | 14 +
 rtl/sync_unit_if.sv | 22 ++
 rtl/sync_unit_regfile.sv | 20 ++
 rtl/sync_unit.sv | 85 ++++++++
 tb/tb_sync_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sync_unit_pkg.sv
// sync_pkg: op, response-type and flag-offset encodings shared by the sync unit
package sync_pkg;
  localparam logic [2:0] OP_READ = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b111;
  localparam logic [2:0] OP_FADD = 3'b010;
  localparam logic [2:0] OP_CAS = 3'b100;
  localparam logic [2:0] OP_WAIT = 3'b011;
  localparam logic [2:0] RT_WRITE = 3'b110;
  localparam logic [2:0] RT_DATA = 3'b101;
  localparam logic [2:0] RT_ILLEGAL = 3'b000;
  localparam int FLAG_CAS = 0;
  localparam int FLAG_TMO = 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/sync_unit_if.sv
// sync_unit_if: request/response bus of the sync unit
interface sync_unit_if #(parameter int ID_W = 4, parameter int LINE_W = 512);
  logic req_valid, req_ready;
  logic [35:0] req_addr;
  logic [2:0] req_op;
  logic [ID_W-1:0] req_id;
  logic [LINE_W-1:0] req_data;
  logic resp_valid, resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [35:0] resp_addr;
  logic [2:0] resp_type;
  logic [LINE_W-1:0] resp_data;
  logic overwrite;
  modport master (
    output req_valid, req_addr, req_op, req_id, req_data, resp_ready,
    input req_ready, resp_valid, resp_id, resp_addr, resp_type, resp_data, overwrite
  );
  modport slave (
    input req_valid, req_addr, req_op, req_id, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_addr, resp_type, resp_data, overwrite
  );
endinterface

// File: rtl/sync_unit_regfile.sv
// sync_regfile: sync register array, one combinational read port and one write port
module sync_regfile #(
  parameter int NUM_REGS = 16,
  parameter int REG_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr_i,
  output logic [REG_W-1:0] rd_data_o,
  input  logic we_i,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr_i,
  input  logic [REG_W-1:0] wr_data_i
);
  logic [REG_W-1:0] regs_q [NUM_REGS];
  assign rd_data_o = regs_q[rd_addr_i];
  // storage with async clear
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (we_i) regs_q[wr_addr_i] <= wr_data_i;
endmodule

// File: rtl/sync_unit.sv
// sync_unit: atomic read/write/fetch-add/CAS/wait unit over a small register file
module sync_unit
  import sync_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int REG_W = 32,
  parameter int LINE_W = 512,
  parameter int ID_W = 4,
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  sync_unit_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [REG_W-1:0] tgt_q, rd_data, fadd, new_val;
  logic [AW-1:0] widx_q, ridx;
  logic acc, we, legal, cas_hit, wait_ok, unused;
  logic [2:0] op, rtype;
  logic [LINE_W-1:0] rdata, wdata;
  assign op = bus.req_op;
  assign bus.req_ready = state_q == S_IDLE || (state_q == S_RESP && bus.resp_ready);
  assign acc = bus.req_valid && bus.req_ready;
  assign ridx = state_q == S_WAIT ? widx_q : bus.req_addr[AW+1:2];
  assign fadd = rd_data + {{(REG_W-15){bus.req_data[46]}}, bus.req_data[46:32]};
  assign cas_hit = rd_data == bus.req_data[REG_W-1:0];
  assign wait_ok = rd_data >= tgt_q;
  assign legal = op inside {OP_READ, OP_WRITE, OP_FADD, OP_CAS, OP_WAIT};
  assign new_val = op == OP_WRITE ? bus.req_data[REG_W-1:0] : op == OP_FADD ? fadd : bus.req_data[REG_W+31:32];
  assign we = acc && (op == OP_WRITE || op == OP_FADD || (op == OP_CAS && cas_hit));
  assign rtype = op == OP_WRITE ? RT_WRITE : legal ? RT_DATA : RT_ILLEGAL;
  assign unused = ^{bus.req_addr, bus.req_data};
  sync_regfile #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) u_rf (
    .clk(clk), .rst(rst), .rd_addr_i(ridx), .rd_data_o(rd_data),
    .we_i(we), .wr_addr_i(ridx), .wr_data_i(new_val)
  );
  // response words: value in the low bits, status flags just above it
  always_comb begin
    rdata = '0;
    rdata[REG_W-1:0] = op == OP_WRITE ? new_val : legal ? rd_data : '0;
    rdata[REG_W+FLAG_CAS] = op == OP_CAS && cas_hit;
    wdata = '0;
    wdata[REG_W-1:0] = rd_data;
    wdata[REG_W+FLAG_TMO] = !wait_ok;
  end
  // control FSM with registered response fields
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      tgt_q <= '0;
      widx_q <= '0;
      bus.resp_valid <= 1'b0;
      bus.overwrite <= 1'b0;
      bus.resp_id <= ID_W'(0);
      bus.resp_addr <= '0;
      bus.resp_type <= '0;
      bus.resp_data <= '0;
    end else if (state_q == S_WAIT) begin
      if (wait_ok || cnt_q == CW'(WAIT_TIMEOUT)) begin
        state_q <= S_RESP;
        bus.resp_valid <= 1'b1;
        bus.resp_type <= RT_DATA;
        bus.resp_data <= wdata;
      end else cnt_q <= cnt_q + CW'(1);
    end else if (acc) begin
      bus.resp_id <= bus.req_id;
      bus.resp_addr <= bus.req_addr;
      cnt_q <= CW'(1);
      tgt_q <= bus.req_data[REG_W-1:0];
      widx_q <= ridx;
      state_q <= op == OP_WAIT ? S_WAIT : S_RESP;
      bus.resp_valid <= op != OP_WAIT;
      bus.overwrite <= we;
      bus.resp_type <= rtype;
      bus.resp_data <= rdata;
    end else if (state_q == S_RESP && bus.resp_ready) begin
      state_q <= S_IDLE;
      bus.resp_valid <= 1'b0;
      bus.overwrite <= 1'b0;
    end
endmodule

// File: tb/tb_sync_unit.sv
// tb_sync_unit: directed and random checks of sync_unit against a behavioural model
module tb_sync_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] mdl [16];
  sync_unit_if bi();
  sync_unit_if bt();
  sync_unit dut (.clk(clk), .rst(rst), .bus(bi));
  sync_unit #(.WAIT_TIMEOUT(8)) dut2 (.clk(clk), .rst(rst), .bus(bt));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] o, input logic [511:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic void model(input logic [2:0] op, input int idx, input logic [511:0] d,
                                output logic [2:0] t, output logic [511:0] r, output logic ow);
    logic [31:0] cur;
    int dl;
    cur = mdl[idx];
    r = '0;
    ow = 1'b0;
    t = 3'b101;
    if (op == 3'b111) begin
      mdl[idx] = d[31:0];
      r[31:0] = d[31:0];
      t = 3'b110;
      ow = 1'b1;
    end else if (op == 3'b010) begin
      dl = int'(d[46:32]);
      if (dl > 16383) dl -= 32768;
      mdl[idx] = cur + dl;
      r[31:0] = cur;
      ow = 1'b1;
    end else if (op == 3'b100) begin
      r[31:0] = cur;
      if (cur == d[31:0]) begin
        mdl[idx] = d[63:32];
        r[32] = 1'b1;
        ow = 1'b1;
      end
    end else if (op == 3'b000) r[31:0] = cur;
    else if (op == 3'b011) begin
      r[31:0] = cur;
      r[33] = !(cur >= d[31:0]);
    end else t = 3'b000;
  endfunction

  task automatic drive(input logic [2:0] op, input int idx, input logic [511:0] d);
    logic [63:0] a;
    a = {$urandom(), $urandom()};
    a[5:2] = 4'(idx);
    bi.req_valid = 1'b1;
    bi.req_op = op;
    bi.req_addr = a[35:0];
    bi.req_id = 4'($urandom());
    bi.req_data = d;
  endtask

  task automatic accept(output int n);
    n = 0;
    while (!bi.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bi.req_valid = 1'b0;
    chk("accept_bound", n < 100, 1);
  endtask

  task automatic check_resp(input string tag, input logic [2:0] et, input logic [511:0] ed, input logic eo);
    chk({tag, "_valid"}, bi.resp_valid, 1);
    chk({tag, "_type"}, bi.resp_type, et);
    chk({tag, "_data"}, bi.resp_data, ed);
    chk({tag, "_ow"}, bi.overwrite, eo);
    chk({tag, "_id"}, bi.resp_id, bi.req_id);
    chk({tag, "_addr"}, bi.resp_addr, bi.req_addr);
  endtask

  task automatic step(input string tag, input logic [2:0] op, input int idx, input logic [511:0] d);
    logic [2:0] et;
    logic [511:0] ed;
    logic eo;
    int n, lat;
    drive(op, idx, d);
    accept(n);
    model(op, idx, d, et, ed, eo);
    lat = 0;
    while (!bi.resp_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, op == 3'b011 ? 1 : 0);
    check_resp(tag, et, ed, eo);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  initial begin
    logic [511:0] d, ed;
    logic [2:0] et, op;
    logic eo;
    int n, lat, idx;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    bi.req_valid = 1'b0; bi.req_op = '0; bi.req_addr = '0; bi.req_id = '0; bi.req_data = '0; bi.resp_ready = 1'b1;
    bt.req_valid = 1'b0; bt.req_op = '0; bt.req_addr = '0; bt.req_id = '0; bt.req_data = '0; bt.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", bi.resp_valid, 0);
    chk("rst_ow", bi.overwrite, 0);
    chk("rst_type", bi.resp_type, 0);
    chk("rst_data", bi.resp_data, 0);
    chk("rst_id", bi.resp_id, 0);
    chk("rst_addr", bi.resp_addr, 0);
    chk("rst_ready", bi.req_ready, 1);
    chk("rst_ready2", bt.req_ready, 1);
    step("wr3", 3'b111, 3, 512'h10);
    d = '0; d[46:32] = 15'h7FFF;
    step("fadd3", 3'b010, 3, d);
    step("rd3", 3'b000, 3, rnd512());
    step("wr0", 3'b111, 0, 512'hFFFFFFFF);
    d = '0; d[46:32] = 15'h1;
    step("fadd0", 3'b010, 0, d);
    step("rd0", 3'b000, 0, '0);
    d = '0; d[63:32] = 32'd7;
    step("cas5a", 3'b100, 5, d);
    step("cas5b", 3'b100, 5, d);
    drive(3'b011, 2, 512'd4);
    accept(n);
    repeat (3) begin
      chk("wait_ready", bi.req_ready, 0);
      chk("wait_valid", bi.resp_valid, 0);
      @(posedge clk); #1;
    end
    force dut.rd_data = 32'd4;
    @(posedge clk); #1;
    release dut.rd_data;
    check_resp("wait_rel", 3'b101, 512'd4, 0);
    bt.req_valid = 1'b1; bt.req_op = 3'b011; bt.req_addr = 36'h8; bt.req_id = 4'h9; bt.req_data = 512'd5;
    @(posedge clk); #1;
    bt.req_valid = 1'b0;
    lat = 0;
    while (!bt.resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ed = '0; ed[33] = 1'b1;
    chk("tmo_lat", lat, 8);
    chk("tmo_data", bt.resp_data, ed);
    chk("tmo_type", bt.resp_type, 3'b101);
    chk("tmo_ow", bt.overwrite, 0);
    chk("tmo_id", bt.resp_id, 4'h9);
    chk("tmo_addr", bt.resp_addr, 36'h8);
    bi.resp_ready = 1'b0;
    step("stall_wr", 3'b111, 7, 512'hAA);
    drive(3'b111, 7, 512'h55);
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_valid", bi.resp_valid, 1);
      chk("stall_data", bi.resp_data, 512'hAA);
      chk("stall_ready", bi.req_ready, 0);
      chk("stall_reg", dut.u_rf.regs_q[7], mdl[7]);
    end
    bi.resp_ready = 1'b1;
    @(posedge clk); #1;
    bi.req_valid = 1'b0;
    model(3'b111, 7, 512'h55, et, ed, eo);
    check_resp("stall_wr2", et, ed, eo);
    step("illegal", 3'b001, 7, rnd512());
    step("rd7", 3'b000, 7, '0);
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      idx = $urandom_range(0, 15);
      d = rnd512();
      if (op == 3'b011) d[31:0] = mdl[idx] == 0 ? 32'd0 : $urandom_range(mdl[idx]);
      if (op == 3'b100 && $urandom_range(0, 1) == 1) d[31:0] = mdl[idx];
      step("rand", op, idx, d);
    end
    step("wr9", 3'b111, 9, 512'd3);
    drive(3'b011, 9, 512'd100);
    accept(n);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstw_valid", bi.resp_valid, 0);
    chk("rstw_ow", bi.overwrite, 0);
    chk("rstw_data", bi.resp_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    chk("rstw_ready", bi.req_ready, 1);
    for (int i = 0; i < 16; i++) step("rst_rd", 3'b000, i, rnd512());
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
